// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the Execute-stage divider.
//   div_state_t   : divider FSM state encoding
//   DIV_ITER      : number of restoring iterations (one per quotient bit)
//   DIV_CNT_W     : width of the iteration counter
//   DIV0_QUOTIENT : quotient reported for a zero divisor
// Optional feature macro: SIGNED_DIV_EN (adds the FIX state).
// -----------------------------------------------------------------------------
package exec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
`ifdef SIGNED_DIV_EN
      ST_FIX  = 2'd2,
`endif
      ST_DONE = 2'd3
   } div_state_t;

   localparam int          DIV_ITER      = 16;
   localparam int          DIV_CNT_W     = 5;
   localparam logic [15:0] DIV0_QUOTIENT = 16'hFFFF;

endpackage

// File: rtl/addsub_16bit.sv
// -----------------------------------------------------------------------------
// addsub_16bit
// 16-bit adder/subtractor built as a ripple of four 4-bit slices.
//   a, b : operands
//   sub  : 1 = a - b (b inverted, carry-in 1), 0 = a + b
//   sum  : result
//   cout : carry-out of the top slice; in subtract mode 1 means "no borrow"
// -----------------------------------------------------------------------------
module addsub_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        sub,
   output logic [15:0] sum,
   output logic        cout
);

   logic [15:0] b_eff;

   assign b_eff = b ^ {16{sub}};

   // Carry chain kept in a procedural variable so each slice's carry-in is the
   // previous slice's carry-out without a self-referencing net vector.
   always_comb begin
      logic       carry;
      logic [4:0] slice_sum;
      carry     = sub;
      sum       = '0;
      slice_sum = '0;
      for (int s = 0; s < 4; s++) begin
         slice_sum      = {1'b0, a[s*4 +: 4]} + {1'b0, b_eff[s*4 +: 4]} + {4'b0000, carry};
         sum[s*4 +: 4]  = slice_sum[3:0];
         carry          = slice_sum[4];
      end
      cout = carry;
   end

endmodule

// File: rtl/div_16bit.sv
// -----------------------------------------------------------------------------
// div_16bit
// Multi-cycle restoring divider, one quotient bit per clock.
//   clk, rst   : clock, synchronous active-high reset
//   start      : divide request, honoured only in IDLE
//   dividend   : numerator, captured on an accepted start
//   divisor    : denominator, captured on an accepted start
//   sgn        : signed operation (only with SIGNED_DIV_EN)
//   busy       : high while iterating / sign-fixing
//   done       : one-cycle pulse when results become valid
//   quotient   : result, held until the next accepted start
//   remainder  : result, held until the next accepted start
//   div0       : divisor was zero
//   ovfl       : signed overflow (-32768 / -1); constant 0 without the macro
// Optional feature macro: SIGNED_DIV_EN.
// Latency: 17 cycles unsigned, 18 signed, 1 for a zero divisor.
// WIDTH is fixed at 16; other values are not supported.
// -----------------------------------------------------------------------------
module div_16bit
   import exec_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
   input  logic             sgn,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div0,
   output logic             ovfl
);

   div_state_t           state_reg;
   logic [WIDTH-1:0]     r_reg;
   logic [WIDTH-1:0]     q_reg;
   logic [WIDTH-1:0]     d_reg;
   logic [DIV_CNT_W-1:0] cnt_reg;
   logic                 busy_reg;
   logic                 done_reg;
   logic [WIDTH-1:0]     quotient_reg;
   logic [WIDTH-1:0]     remainder_reg;
   logic                 div0_reg;

   logic [WIDTH-1:0]     shifted_next;
   logic [WIDTH-1:0]     diff_next;
   logic                 step_cout;
   logic                 step_ok;
   logic [WIDTH-1:0]     r_next;
   logic [WIDTH-1:0]     q_next;
   logic [WIDTH-1:0]     as_a;
   logic [WIDTH-1:0]     as_b;
   logic [WIDTH-1:0]     dvd_load;
   logic [WIDTH-1:0]     dvs_load;

   // Partial remainder shifted left with the next dividend bit brought in.
   assign shifted_next = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};

`ifdef SIGNED_DIV_EN
   logic             ovfl_reg;
   logic             neg_q_reg;
   logic             neg_r_reg;
   logic             signed_reg;
   logic [WIDTH-1:0] rem_neg;
   logic             rem_cout_unused;

   // The step adder doubles as the quotient negator (0 - q) during FIX.
   assign as_a = (state_reg == ST_FIX) ? '0           : shifted_next;
   assign as_b = (state_reg == ST_FIX) ? quotient_reg : d_reg;

   addsub_16bit u_rem_neg (
      .a    ('0),
      .b    (remainder_reg),
      .sub  (1'b1),
      .sum  (rem_neg),
      .cout (rem_cout_unused)
   );

   // Signed operands are reduced to magnitudes before iterating.
   assign dvd_load = (sgn && dividend[WIDTH-1]) ? (~dividend + 16'd1) : dividend;
   assign dvs_load = (sgn && divisor[WIDTH-1])  ? (~divisor + 16'd1)  : divisor;
   assign ovfl     = ovfl_reg;
`else
   assign as_a     = shifted_next;
   assign as_b     = d_reg;
   assign dvd_load = dividend;
   assign dvs_load = divisor;
   assign ovfl     = 1'b0;
`endif

   addsub_16bit u_step (
      .a    (as_a),
      .b    (as_b),
      .sub  (1'b1),
      .sum  (diff_next),
      .cout (step_cout)
   );

   // The bit shifted out of r_reg is the 17th bit of the trial value; when it
   // is set the trial value is at least 2^16 and certainly exceeds the divisor,
   // so the subtraction succeeds even though the 16-bit adder reports a borrow.
   assign step_ok = step_cout | r_reg[WIDTH-1];
   assign r_next  = step_ok ? diff_next : shifted_next;
   assign q_next  = {q_reg[WIDTH-2:0], step_ok};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         r_reg         <= '0;
         q_reg         <= '0;
         d_reg         <= '0;
         cnt_reg       <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         div0_reg      <= 1'b0;
`ifdef SIGNED_DIV_EN
         ovfl_reg      <= 1'b0;
         neg_q_reg     <= 1'b0;
         neg_r_reg     <= 1'b0;
         signed_reg    <= 1'b0;
`endif
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  quotient_reg  <= '0;
                  remainder_reg <= '0;
                  div0_reg      <= 1'b0;
`ifdef SIGNED_DIV_EN
                  ovfl_reg      <= 1'b0;
`endif
                  if (divisor == '0) begin
                     quotient_reg  <= DIV0_QUOTIENT;
                     remainder_reg <= dividend;
                     div0_reg      <= 1'b1;
                     done_reg      <= 1'b1;
                     state_reg     <= ST_DONE;
                  end else begin
                     r_reg     <= '0;
                     q_reg     <= dvd_load;
                     d_reg     <= dvs_load;
                     cnt_reg   <= DIV_CNT_W'(DIV_ITER);
                     busy_reg  <= 1'b1;
                     state_reg <= ST_RUN;
`ifdef SIGNED_DIV_EN
                     signed_reg <= sgn;
                     neg_q_reg  <= sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                     neg_r_reg  <= sgn && dividend[WIDTH-1];
                     // Magnitude path already yields 16'h8000 / 0 here.
                     ovfl_reg   <= sgn && (dividend == 16'h8000) && (divisor == 16'hFFFF);
`endif
                  end
               end
            end

            ST_RUN: begin
               r_reg   <= r_next;
               q_reg   <= q_next;
               cnt_reg <= cnt_reg - 1'b1;
               if (cnt_reg == DIV_CNT_W'(1)) begin
                  quotient_reg  <= q_next;
                  remainder_reg <= r_next;
`ifdef SIGNED_DIV_EN
                  if (signed_reg) begin
                     state_reg <= ST_FIX;
                  end else begin
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                     state_reg <= ST_DONE;
                  end
`else
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= ST_DONE;
`endif
               end
            end

`ifdef SIGNED_DIV_EN
            ST_FIX: begin
               if (neg_q_reg) quotient_reg  <= diff_next;
               if (neg_r_reg) remainder_reg <= rem_neg;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b1;
               state_reg <= ST_DONE;
            end
`endif

            ST_DONE: begin
               state_reg <= ST_IDLE;
            end

            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_reg;
   assign done      = done_reg;
   assign quotient  = quotient_reg;
   assign remainder = remainder_reg;
   assign div0      = div0_reg;

endmodule

// File: doc/div_16bit.md
# div_16bit

- Multi-cycle 16-bit restoring divider for the Execute stage; the inverse-direction companion to the add/sub datapath.
- Takes a dividend and divisor on a start pulse and produces quotient and remainder after a fixed iteration count.
- Each iteration is one subtract-and-restore step built from 4-bit add/sub slices.
- The pipeline stalls on `busy` and captures results on `done`.

## Interface
Parameters:
- `WIDTH`, default 16: operand and result width; only 16 is supported.

Ports:
- `clk` (in, 1): clock; all state changes on the rising edge.
- `rst` (in, 1): reset, synchronous and active-high.
- `start` (in, 1): request a divide; sampled only in IDLE.
- `dividend` (in, 16): numerator; sampled on the accepted `start`.
- `divisor` (in, 16): denominator; sampled on the accepted `start`.
- `sgn` (in, 1): signed operation; present only with `SIGNED_DIV_EN`.
- `busy` (out, 1): divide in progress; `start` is ignored while this is high.
- `done` (out, 1): one-cycle pulse; results are valid from this cycle on.
- `quotient` (out, 16): result; held until the next accepted `start`.
- `remainder` (out, 16): result; held until the next accepted `start`.
- `div0` (out, 1): divisor was zero; held with the results.
- `ovfl` (out, 1): signed overflow; held with the results. Tied to 0 without the macro.

## Operation
- **States:** IDLE, RUN, FIX (present only with the macro), DONE.
- **IDLE:**
  - `start`=1 with `divisor`≠0 loads the registers and goes to RUN: partial remainder R=0, shift register Q=dividend, D=divisor, 5-bit counter=16. The previous results, `div0` and `ovfl` are cleared.
  - `start`=1 with `divisor`=0 goes to DONE with `quotient`=16'hFFFF, `remainder`=`dividend`, `div0`=1.
- **RUN:** each cycle:
  - T = {R[14:0], Q[15]} − D, computed with the sub-module in subtract mode.
  - If the carry-out is 1 (no borrow): R←T, Q←{Q[14:0],1}. Otherwise R←{R[14:0],Q[15]}, Q←{Q[14:0],0}.
  - Counter decrements. Leave RUN when the counter reaches 1: go to FIX if the signed path is active, otherwise DONE.
- **FIX:** sign-correct the results, then go to DONE.
  - Negate the quotient if the operand signs differ.
  - Give the remainder the sign of the dividend.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- `busy` = 1 in RUN and FIX, 0 otherwise.
- **Arithmetic:** unsigned invariant dividend = quotient·divisor + remainder, with remainder < divisor.
- **Boundary cases:**
  - `start` while busy or in DONE is ignored; it is not queued.
  - Reset at any point, including mid-RUN, returns to IDLE and zeroes every output next cycle.
  - Dividend 0 gives Q=0, R=0 after the full latency; there is no early exit.

## Timing
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div0`=0, `ovfl`=0, state IDLE.
- With `start` accepted at edge N:
  - `busy` is high from cycle N+1 through N+16.
  - Unsigned: `done` is high in cycle N+17; latency is 17 cycles.
  - Signed: FIX adds one cycle, so `done` is at N+18.
  - Divide-by-zero: `done` is at N+1 and `busy` never rises.
- Earliest back-to-back `start`: the cycle after `done`, once back in IDLE.

## Configuration
Macro: `SIGNED_DIV_EN`.

Defined:
- The `sgn` port exists.
- With `sgn`=1, operands are converted to magnitudes at load and FIX is inserted.
- −32768 / −1 sets `ovfl`=1, `quotient`=16'h8000, `remainder`=0.
- Divide-by-zero behaviour is unchanged.

Undefined:
- No `sgn` port and no FIX state.
- Unsigned only; `ovfl` is tied to 0.

## Structure
Shared package `exec_pkg`:
- Divider state enum.
- `DIV_ITER`=16.
- `DIV0_QUOTIENT`=16'hFFFF.

One sub-module: `addsub_16bit`, a ripple of four 4-bit add/sub slices providing the difference and carry-out used by RUN and by FIX negation.

## Test plan
- **Basic unsigned:** 100/7 → Q=14, R=2, `done` exactly 17 cycles after `start`, `busy` high for 16 cycles.
- **Full-range:** 16'hFFFF/1 → Q=16'hFFFF, R=0.
- **Zero divisor:** 5/0 → `div0`=1, Q=16'hFFFF, R=5, `done` on the cycle after `start`, `busy` stays 0.
- **Start while busy:** 1000/10 started, then `start` with 9/3 at cycle 5 → Q=100, R=0, and no second `done`.
- **Reset mid-operation:** reset at cycle 8 of RUN → all outputs 0 and IDLE next cycle. A fresh 50/8 then returns Q=6, R=2.
- **Signed (macro on):**
  - −7/2 → Q=16'hFFFD, R=16'hFFFF, `done` at 18 cycles.
  - −32768/−1 → `ovfl`=1, Q=16'h8000, R=0.
